// File: rtl/bitonic_pkg.sv
// Schedule helpers for the bitonic sorting network: stage count, pair partner and
// per-pair sort direction, all evaluated at elaboration time.
package bitonic_pkg;

    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int k = 1; k < n; k = k * 2) r++;
        return r;
    endfunction

    function automatic int num_stages(input int depth);
        int l;
        l = log2(depth);
        return l * (l + 1) / 2;
    endfunction

    // Stages are enumerated merge level p = 0..L-1, then distance 2^q for q = p..0.
    function automatic int stage_level(input int depth, input int stage);
        int k;
        int lvl;
        k   = 0;
        lvl = 0;
        for (int p = 0; p < log2(depth); p++) begin
            for (int q = p; q >= 0; q--) begin
                if (k == stage) lvl = p;
                k++;
            end
        end
        return lvl;
    endfunction

    function automatic int stage_shift(input int depth, input int stage);
        int k;
        int sh;
        k  = 0;
        sh = 0;
        for (int p = 0; p < log2(depth); p++) begin
            for (int q = p; q >= 0; q--) begin
                if (k == stage) sh = q;
                k++;
            end
        end
        return sh;
    endfunction

    function automatic int partner(input int depth, input int stage, input int i);
        return i ^ (1 << stage_shift(depth, stage));
    endfunction

    // 1 = this pair sorts descending within its bitonic block.
    function automatic bit dir(input int depth, input int stage, input int i);
        return ((i >> (stage_level(depth, stage) + 1)) & 1) != 0;
    endfunction

endpackage

// File: rtl/bitonic_cas.sv
// One compare-and-swap cell. Key is {value, original index}, so the order is total
// and ties between equal values resolve deterministically by index.
module bitonic_cas #(
    parameter int WIDTH  = 32,
    parameter int IW     = 3,
    parameter bit SIGNED = 1'b1
) (
    input  logic [WIDTH+IW-1:0] a,
    input  logic [WIDTH+IW-1:0] b,
    input  logic                desc,
    output logic [WIDTH+IW-1:0] lo,
    output logic [WIDTH+IW-1:0] hi
);
    typedef struct packed {
        logic [WIDTH-1:0] val;
        logic [IW-1:0]    idx;
    } elem_t;

    elem_t ea;
    elem_t eb;
    logic  a_gt_b;
    logic  swap;

    assign ea = a;
    assign eb = b;

    always_comb begin
        if (ea.val != eb.val) begin
            if (SIGNED) a_gt_b = $signed(ea.val) > $signed(eb.val);
            else        a_gt_b = ea.val > eb.val;
        end else begin
            a_gt_b = ea.idx > eb.idx;
        end
    end

    // Keys are never equal, so XOR with desc is an exact direction flip.
    assign swap = a_gt_b ^ desc;
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/bitonic_sort_stream.sv
// Fully pipelined bitonic sorter with argsort indices, per-vector direction, tag sideband
// and a single global stall enable driven by output backpressure.
module bitonic_sort_stream
    import bitonic_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter bit SIGNED = 1'b1,
    parameter int TAG_W  = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [DEPTH-1:0][WIDTH-1:0]             in_data,
    input  logic                                    in_desc,
    input  logic [TAG_W-1:0]                        in_tag,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [DEPTH-1:0][WIDTH-1:0]             out_data,
    output logic [DEPTH-1:0][$clog2(DEPTH)-1:0]     out_idx,
    output logic                                    out_desc,
    output logic [TAG_W-1:0]                        out_tag
);
    localparam int IW     = $clog2(DEPTH);
    localparam int EW     = WIDTH + IW;
    localparam int NSTAGE = num_stages(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("bitonic_sort_stream: DEPTH must be a power of 2 and >= 2");
    end

    logic                                en;
    logic [NSTAGE-1:0]                   rank_valid;
    logic [NSTAGE-1:0]                   rank_desc;
    logic [NSTAGE-1:0][TAG_W-1:0]        rank_tag;
    logic [NSTAGE-1:0][DEPTH-1:0][EW-1:0] rank_data;

    logic [NSTAGE-1:0]                   stage_valid;
    logic [NSTAGE-1:0]                   stage_desc;
    logic [NSTAGE-1:0][TAG_W-1:0]        stage_tag;
    logic [NSTAGE-1:0][DEPTH-1:0][EW-1:0] stage_in;
    logic [NSTAGE-1:0][DEPTH-1:0][EW-1:0] stage_out;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage 0 works on the raw inputs; every later stage reads the previous rank.
    for (genvar i = 0; i < DEPTH; i++) begin : g_load
        assign stage_in[0][i] = {in_data[i], IW'(i)};
    end
    assign stage_valid[0] = in_valid;
    assign stage_desc[0]  = in_desc;
    assign stage_tag[0]   = in_tag;

    for (genvar s = 1; s < NSTAGE; s++) begin : g_link
        assign stage_in[s]    = rank_data[s-1];
        assign stage_valid[s] = rank_valid[s-1];
        assign stage_desc[s]  = rank_desc[s-1];
        assign stage_tag[s]   = rank_tag[s-1];
    end

    for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
        for (genvar i = 0; i < DEPTH; i++) begin : g_pair
            if (partner(DEPTH, s, i) > i) begin : g_cas
                localparam int J   = partner(DEPTH, s, i);
                localparam bit DIR = dir(DEPTH, s, i);
                bitonic_cas #(
                    .WIDTH  (WIDTH),
                    .IW     (IW),
                    .SIGNED (SIGNED)
                ) u_cas (
                    .a    (stage_in[s][i]),
                    .b    (stage_in[s][J]),
                    .desc (DIR ^ stage_desc[s]),
                    .lo   (stage_out[s][i]),
                    .hi   (stage_out[s][J])
                );
            end
        end
    end

    // NOTE: data ranks are reset along with valid so outputs read as zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rank_valid <= '0;
            rank_desc  <= '0;
            rank_tag   <= '0;
            rank_data  <= '0;
        end else if (en) begin
            rank_valid <= stage_valid;
            rank_desc  <= stage_desc;
            rank_tag   <= stage_tag;
            rank_data  <= stage_out;
        end
    end

    assign out_valid = rank_valid[NSTAGE-1];
    assign out_desc  = rank_desc[NSTAGE-1];
    assign out_tag   = rank_tag[NSTAGE-1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_out
        assign out_data[i] = rank_data[NSTAGE-1][i][EW-1:IW];
        assign out_idx[i]  = rank_data[NSTAGE-1][i][IW-1:0];
    end

endmodule

// File: tb/tb_bitonic_sort_stream.sv
// Scoreboard bench: a signed and an unsigned sorter share stimulus; a monitor pops expected
// vectors whenever each DUT presents an output.
module tb_bitonic_sort_stream;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 8;
    localparam int TAG_W  = 4;
    localparam int IW     = 3;
    localparam int NSTAGE = 6;

    typedef logic [DEPTH-1:0][WIDTH-1:0] data_t;
    typedef logic [DEPTH-1:0][IW-1:0]    idx_t;
    typedef int arr_t [DEPTH];
    typedef struct {
        data_t            data;
        idx_t             idx;
        logic             desc;
        logic [TAG_W-1:0] tag;
        int               issue_cyc;
        bit               chk_lat;
    } exp_t;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_desc   = 1'b0;
    logic             out_ready = 1'b1;
    data_t            in_data   = '0;
    logic [TAG_W-1:0] in_tag    = '0;

    logic             in_ready_u  [2];
    logic             out_valid_u [2];
    data_t            out_data_u  [2];
    idx_t             out_idx_u   [2];
    logic             out_desc_u  [2];
    logic [TAG_W-1:0] out_tag_u   [2];

    exp_t exp_q [2][$];
    exp_t mon_e;
    int   pops [2];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bitonic_sort_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SIGNED(1'b1), .TAG_W(TAG_W)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u[0]),
        .in_data(in_data), .in_desc(in_desc), .in_tag(in_tag),
        .out_valid(out_valid_u[0]), .out_ready(out_ready), .out_data(out_data_u[0]),
        .out_idx(out_idx_u[0]), .out_desc(out_desc_u[0]), .out_tag(out_tag_u[0])
    );

    bitonic_sort_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SIGNED(1'b0), .TAG_W(TAG_W)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u[1]),
        .in_data(in_data), .in_desc(in_desc), .in_tag(in_tag),
        .out_valid(out_valid_u[1]), .out_ready(out_ready), .out_data(out_data_u[1]),
        .out_idx(out_idx_u[1]), .out_desc(out_desc_u[1]), .out_tag(out_tag_u[1])
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic data_t to_data(input arr_t a);
        data_t d;
        for (int i = 0; i < DEPTH; i++) d[i] = a[i];
        return d;
    endfunction

    function automatic idx_t to_idx(input arr_t a);
        idx_t x;
        for (int i = 0; i < DEPTH; i++) x[i] = IW'(a[i]);
        return x;
    endfunction

    // Present one vector, wait for the handshake, then queue the expected result per DUT.
    task automatic send(input arr_t vals, input bit desc, input logic [TAG_W-1:0] tag,
                        input arr_t s_d, input arr_t s_i, input arr_t u_d, input arr_t u_i,
                        input bit lat);
        bit   acc;
        int   guard;
        int   issue;
        exp_t e;
        acc      = 1'b0;
        guard    = 0;
        issue    = 0;
        in_valid = 1'b1;
        in_data  = to_data(vals);
        in_desc  = desc;
        in_tag   = tag;
        while (!acc) begin
            @(negedge clk);
            acc   = in_ready_u[0];
            issue = cyc;
            @(posedge clk);
            #1;
            guard++;
            if (!acc && guard > 50) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
        if (acc) begin
            e.desc = desc; e.tag = tag; e.issue_cyc = issue; e.chk_lat = lat;
            e.data = to_data(s_d); e.idx = to_idx(s_i);
            exp_q[0].push_back(e);
            e.data = to_data(u_d); e.idx = to_idx(u_i);
            exp_q[1].push_back(e);
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_timeout", guard >= 200, 0);
    endtask

    task automatic wait_pops(input int n);
        int guard;
        guard = 0;
        while (pops[0] < n && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("pop_timeout", guard >= 200, 0);
    endtask

    // Monitor: compare against the queue head whenever a DUT shows out_valid.
    initial begin
        pops[0] = 0;
        pops[1] = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int u = 0; u < 2; u++) begin
                    if (out_valid_u[u]) begin
                        if (exp_q[u].size() == 0) begin
                            check($sformatf("u%0d_unexpected_out", u), 1, 0);
                        end else begin
                            mon_e = exp_q[u][0];
                            check($sformatf("u%0d_data", u), out_data_u[u], mon_e.data);
                            check($sformatf("u%0d_idx", u), out_idx_u[u], mon_e.idx);
                            check($sformatf("u%0d_desc_tag", u), {out_desc_u[u], out_tag_u[u]},
                                  {mon_e.desc, mon_e.tag});
                            if (out_ready) begin
                                if (mon_e.chk_lat)
                                    check($sformatf("u%0d_latency", u), cyc - mon_e.issue_cyc, NSTAGE);
                                exp_q[u].delete(0);
                                pops[u]++;
                            end else begin
                                check($sformatf("u%0d_in_ready_stall", u), in_ready_u[u], 0);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        arr_t v, ed, ei, sd, si, ud, ui;
        int   base;

        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d_rst_valid", u), out_valid_u[u], 0);
            check($sformatf("u%0d_rst_data", u), out_data_u[u], 0);
            check($sformatf("u%0d_rst_idx", u), out_idx_u[u], 0);
            check($sformatf("u%0d_rst_desc_tag", u), {out_desc_u[u], out_tag_u[u]}, 0);
            check($sformatf("u%0d_rst_in_ready", u), in_ready_u[u], 1);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic permutation, ascending then descending.
        v  = '{3, 1, 2, 0, 7, 5, 6, 4};
        ed = '{0, 1, 2, 3, 4, 5, 6, 7};
        ei = '{3, 1, 2, 0, 7, 5, 6, 4};
        send(v, 1'b0, 4'd5, ed, ei, ed, ei, 1'b1);
        wait_drain();
        ed = '{7, 6, 5, 4, 3, 2, 1, 0};
        ei = '{4, 6, 5, 7, 0, 2, 1, 3};
        send(v, 1'b1, 4'd6, ed, ei, ed, ei, 1'b0);

        // All-equal values: index decides.
        v  = '{7, 7, 7, 7, 7, 7, 7, 7};
        ei = '{0, 1, 2, 3, 4, 5, 6, 7};
        send(v, 1'b0, 4'd1, v, ei, v, ei, 1'b0);
        ei = '{7, 6, 5, 4, 3, 2, 1, 0};
        send(v, 1'b1, 4'd2, v, ei, v, ei, 1'b0);

        // Signed vs unsigned extremes, back-to-back with mixed directions.
        v  = '{-2147483647 - 1, 2147483647, 0, -1, 1, 123, -123, 0};
        sd = '{-2147483647 - 1, -123, -1, 0, 0, 1, 123, 2147483647};
        si = '{0, 6, 3, 2, 7, 4, 5, 1};
        ud = '{0, 0, 1, 123, 2147483647, -2147483647 - 1, -123, -1};
        ui = '{2, 7, 4, 5, 1, 0, 6, 3};
        send(v, 1'b0, 4'd3, sd, si, ud, ui, 1'b0);
        sd = '{2147483647, 123, 1, 0, 0, -1, -123, -2147483647 - 1};
        si = '{1, 5, 4, 7, 2, 3, 6, 0};
        ud = '{-1, -123, -2147483647 - 1, 2147483647, 123, 1, 0, 0};
        ui = '{3, 6, 0, 1, 5, 4, 7, 2};
        send(v, 1'b1, 4'd4, sd, si, ud, ui, 1'b0);
        wait_drain();

        // Six back-to-back vectors, then a 3-cycle stall with a seventh vector pending.
        base = pops[0];
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                v[i] = 8 * k + 7 - i;
                if (k % 2 == 0) begin ed[i] = 8 * k + i;     ei[i] = 7 - i; end
                else            begin ed[i] = 8 * k + 7 - i; ei[i] = i;     end
            end
            if (k == 6) begin
                wait_pops(base + 2);
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_data   = to_data(v);
                in_desc   = 1'b0;
                in_tag    = 4'd14;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
            send(v, (k % 2) == 1, TAG_W'(8 + k), ed, ei, ed, ei, 1'b0);
        end
        wait_drain();
        check("stream_pops", pops[0] - base, 7);

        // Reset with four vectors in flight, first one just reaching the output.
        for (int k = 10; k < 14; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                v[i] = 8 * k + 7 - i; ed[i] = 8 * k + i; ei[i] = 7 - i;
            end
            send(v, 1'b0, TAG_W'(k), ed, ei, ed, ei, 1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        check("inflight_valid", out_valid_u[0], 1);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q[0].delete();
        exp_q[1].delete();
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d_midrst_valid", u), out_valid_u[u], 0);
            check($sformatf("u%0d_midrst_data", u), out_data_u[u], 0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("postrst_valid", out_valid_u[0] | out_valid_u[1], 0);
        end
        v  = '{3, 1, 2, 0, 7, 5, 6, 4};
        ed = '{0, 1, 2, 3, 4, 5, 6, 7};
        ei = '{3, 1, 2, 0, 7, 5, 6, 4};
        send(v, 1'b0, 4'd9, ed, ei, ed, ei, 1'b1);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
